// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game bullet logic.
// Positions are 10.6 unsigned fixed point; velocities are signed 10-bit in
// the same fractional scale.
package tank_pkg;

    localparam int FRAC_BITS = 6;

    localparam int SCREEN_X_MIN = 0;
    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MIN = 0;
    localparam int SCREEN_Y_MAX = 479;

    typedef logic signed [9:0] vel_t;

    typedef struct packed {
        logic        active;
        logic [15:0] pos_x;
        logic [15:0] pos_y;
        logic [9:0]  vx;
        logic [9:0]  vy;
        logic [7:0]  life;
    } bullet_t;

    // Magnitude of a 12-bit signed distance (inputs never reach -2048).
    function automatic logic signed [11:0] abs12(input logic signed [11:0] v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet: spawn load, per-frame move, bound handling, lifetime expiry
// and overlap test against the enemy box.
// Build option: BULLET_BOUNCE_EN selects reflection off the playfield bounds;
// without it a bullet leaving the playfield is removed.
module bullet_slot
    import tank_pkg::*;
#(
    parameter int LIFETIME    = 200,
    parameter int BULLET_SIZE = 2,
    parameter int X_MIN       = SCREEN_X_MIN,
    parameter int X_MAX       = SCREEN_X_MAX,
    parameter int Y_MIN       = SCREEN_Y_MIN,
    parameter int Y_MAX       = SCREEN_Y_MAX
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spawn_i,
    input  logic [9:0]  spawn_x_i,
    input  logic [9:0]  spawn_y_i,
    input  logic [9:0]  spawn_vx_i,
    input  logic [9:0]  spawn_vy_i,
    input  logic [5:0]  spawn_angle_i,
    input  logic [9:0]  enemy_x_i,
    input  logic [9:0]  enemy_y_i,
    input  logic [9:0]  enemy_s_i,
    output bullet_t     state_o,
    output logic [5:0]  angle_o,
    output logic        collide_o
);

    localparam logic signed [16:0] X_LO = 17'(X_MIN * (1 << FRAC_BITS));
    localparam logic signed [16:0] X_HI = 17'(X_MAX * (1 << FRAC_BITS));
    localparam logic signed [16:0] Y_LO = 17'(Y_MIN * (1 << FRAC_BITS));
    localparam logic signed [16:0] Y_HI = 17'(Y_MAX * (1 << FRAC_BITS));

    bullet_t            slot_q, slot_d;
    logic [5:0]         angle_q, angle_d;
    logic signed [16:0] next_x, next_y;
    logic               out_x, out_y;
    logic signed [11:0] dist_x, dist_y, hit_lim;

    // Candidate next position and overlap test on the registered position.
    always_comb begin
        next_x  = {1'b0, slot_q.pos_x} + {{7{slot_q.vx[9]}}, slot_q.vx};
        next_y  = {1'b0, slot_q.pos_y} + {{7{slot_q.vy[9]}}, slot_q.vy};
        out_x   = (next_x < X_LO) || (next_x > X_HI);
        out_y   = (next_y < Y_LO) || (next_y > Y_HI);
        dist_x  = signed'({2'b00, slot_q.pos_x[15:FRAC_BITS]}) - signed'({2'b00, enemy_x_i});
        dist_y  = signed'({2'b00, slot_q.pos_y[15:FRAC_BITS]}) - signed'({2'b00, enemy_y_i});
        hit_lim = signed'({2'b00, enemy_s_i}) + signed'(12'(BULLET_SIZE));
        collide_o = slot_q.active && (abs12(dist_x) <= hit_lim) && (abs12(dist_y) <= hit_lim);
    end

    // Slot next state: spawn into a free slot, else hit-clear > expiry > move.
    always_comb begin
        slot_d  = slot_q;
        angle_d = angle_q;
        if (spawn_i) begin
            slot_d.active = 1'b1;
            slot_d.pos_x  = {spawn_x_i, {FRAC_BITS{1'b0}}};
            slot_d.pos_y  = {spawn_y_i, {FRAC_BITS{1'b0}}};
            slot_d.vx     = spawn_vx_i;
            slot_d.vy     = spawn_vy_i;
            slot_d.life   = 8'(LIFETIME);
            angle_d       = spawn_angle_i;
        end else if (slot_q.active) begin
            if (collide_o || (slot_q.life == 8'd1)) begin
                slot_d.active = 1'b0;
                slot_d.life   = 8'd0;
            end else begin
`ifdef BULLET_BOUNCE_EN
                if (out_x) slot_d.vx    = -slot_q.vx;
                else       slot_d.pos_x = next_x[15:0];
                if (out_y) slot_d.vy    = -slot_q.vy;
                else       slot_d.pos_y = next_y[15:0];
                slot_d.life = slot_q.life - 8'd1;
`else
                if (out_x || out_y) begin
                    slot_d.active = 1'b0;
                    slot_d.life   = 8'd0;
                end else begin
                    slot_d.pos_x = next_x[15:0];
                    slot_d.pos_y = next_y[15:0];
                    slot_d.life  = slot_q.life - 8'd1;
                end
`endif
            end
        end
    end

    // Slot state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q  <= '0;
            angle_q <= '0;
        end else begin
            slot_q  <= slot_d;
            angle_q <= angle_d;
        end
    end

    assign state_o = slot_q;
    assign angle_o = angle_q;

endmodule

// File: rtl/bullet_ctrl.sv
// Bullet pool controller: fire edge detect, cooldown, lowest-free slot
// allocation, Hit pulse and packing of slot state for the colour mapper.
// Build option: BULLET_BOUNCE_EN (reflect off bounds instead of removing).
module bullet_ctrl
    import tank_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int LIFETIME    = 200,
    parameter int COOLDOWN    = 8,
    parameter int SPEED_LOG2  = 1,
    parameter int BULLET_SIZE = 2,
    parameter int X_MIN       = SCREEN_X_MIN,
    parameter int X_MAX       = SCREEN_X_MAX,
    parameter int Y_MIN       = SCREEN_Y_MIN,
    parameter int Y_MAX       = SCREEN_Y_MAX
) (
    input  logic                     frame_clk,
    input  logic                     Reset,
    input  logic                     ShootBullet,
    input  logic [9:0]               TankX,
    input  logic [9:0]               TankY,
    input  logic [7:0]               sin,
    input  logic [7:0]               cos,
    input  logic [5:0]               Angle,
    input  logic [9:0]               EnemyX,
    input  logic [9:0]               EnemyY,
    input  logic [9:0]               EnemyS,
    output logic [10*NUM_BULLETS-1:0] BulletX,
    output logic [10*NUM_BULLETS-1:0] BulletY,
    output logic [NUM_BULLETS-1:0]   BulletActive,
    output logic [9:0]               BulletS,
    output logic                     Hit
);

    logic                   shoot_prev_q;
    logic [7:0]             cooldown_q, cooldown_d;
    logic                   hit_q;

    bullet_t                slot_state [NUM_BULLETS];
    logic [5:0]             slot_angle [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] active_vec;
    logic [NUM_BULLETS-1:0] collide_vec;
    logic [NUM_BULLETS-1:0] spawn_vec;
    logic                   any_free, accept, found;
    vel_t                   cos_ext, sin_ext, spawn_vx, spawn_vy;

    assign cos_ext  = {{2{cos[7]}}, cos};
    assign sin_ext  = {{2{sin[7]}}, sin};
    assign spawn_vx = cos_ext <<< SPEED_LOG2;
    assign spawn_vy = sin_ext <<< SPEED_LOG2;

    assign any_free = ~&active_vec;
    assign accept   = ShootBullet && !shoot_prev_q && (cooldown_q == 8'd0) && any_free;

    // Pick the lowest-index free slot from the registered active flags.
    always_comb begin
        spawn_vec = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!active_vec[i] && !found) begin
                spawn_vec[i] = accept;
                found        = 1'b1;
            end
        end
    end

    // Cooldown reload on an accepted shot, otherwise count down to zero.
    always_comb begin
        cooldown_d = cooldown_q;
        if (accept)                  cooldown_d = 8'(COOLDOWN);
        else if (cooldown_q != 8'd0) cooldown_d = cooldown_q - 8'd1;
    end

    // Fire edge history, cooldown counter and registered Hit pulse.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            shoot_prev_q <= 1'b0;
            cooldown_q   <= 8'd0;
            hit_q        <= 1'b0;
        end else begin
            shoot_prev_q <= ShootBullet;
            cooldown_q   <= cooldown_d;
            hit_q        <= |collide_vec;
        end
    end

    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
        bullet_slot #(
            .LIFETIME    (LIFETIME),
            .BULLET_SIZE (BULLET_SIZE),
            .X_MIN       (X_MIN),
            .X_MAX       (X_MAX),
            .Y_MIN       (Y_MIN),
            .Y_MAX       (Y_MAX)
        ) u_slot (
            .clk_i         (frame_clk),
            .rst_i         (Reset),
            .spawn_i       (spawn_vec[i]),
            .spawn_x_i     (TankX),
            .spawn_y_i     (TankY),
            .spawn_vx_i    (spawn_vx),
            .spawn_vy_i    (spawn_vy),
            .spawn_angle_i (Angle),
            .enemy_x_i     (EnemyX),
            .enemy_y_i     (EnemyY),
            .enemy_s_i     (EnemyS),
            .state_o       (slot_state[i]),
            .angle_o       (slot_angle[i]),
            .collide_o     (collide_vec[i])
        );

        assign active_vec[i]        = slot_state[i].active;
        assign BulletX[10*i +: 10]  = slot_state[i].pos_x[15:FRAC_BITS];
        assign BulletY[10*i +: 10]  = slot_state[i].pos_y[15:FRAC_BITS];
    end

    assign BulletActive = active_vec;
    assign BulletS      = 10'(BULLET_SIZE);
    assign Hit          = hit_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Self-checking bench for bullet_ctrl with default parameters.
module tb_bullet_ctrl;

    localparam int NB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              shoot;
    logic [9:0]        tx, ty, ex, ey, es;
    logic signed [7:0] sn, cs;
    logic [5:0]        ang;
    wire  [39:0]       bx, by;
    wire  [3:0]        bact;
    wire  [9:0]        bs;
    wire               hit;

    always #5 clk = ~clk;

    bullet_ctrl dut (
        .frame_clk    (clk),
        .Reset        (rst),
        .ShootBullet  (shoot),
        .TankX        (tx),
        .TankY        (ty),
        .sin          (sn),
        .cos          (cs),
        .Angle        (ang),
        .EnemyX       (ex),
        .EnemyY       (ey),
        .EnemyS       (es),
        .BulletX      (bx),
        .BulletY      (by),
        .BulletActive (bact),
        .BulletS      (bs),
        .Hit          (hit)
    );

    typedef struct {
        logic [3:0]  act;
        logic [39:0] x;
        logic [39:0] y;
        logic        hit;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   fcnt    = 0;

    int m_act[NB], m_x[NB], m_y[NB], m_vx[NB], m_vy[NB], m_life[NB];
    int m_cd, m_prev, m_hit;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
            m_vx[i] = 0; m_vy[i] = 0; m_life[i] = 0;
        end
        m_cd = 0; m_prev = 0; m_hit = 0;
    endtask

    // Reference behaviour for one rising edge, from the current inputs.
    task automatic model_step();
        int coll[NB];
        int hit_any, fr, acc, nx, ny, dx, dy, lim;
        bit ox, oy;
        hit_any = 0;
        fr = -1;
        lim = int'(es) + 2;
        for (int i = 0; i < NB; i++) begin
            coll[i] = 0;
            if (m_act[i] != 0) begin
                dx = (m_x[i] / 64) - int'(ex);
                dy = (m_y[i] / 64) - int'(ey);
                if (dx < 0) dx = -dx;
                if (dy < 0) dy = -dy;
                if (dx <= lim && dy <= lim) begin
                    coll[i] = 1;
                    hit_any = 1;
                end
            end
        end
        for (int i = NB - 1; i >= 0; i--)
            if (m_act[i] == 0) fr = i;
        acc = (shoot && m_prev == 0 && m_cd == 0 && fr >= 0) ? 1 : 0;
        for (int i = 0; i < NB; i++) begin
            if (m_act[i] != 0) begin
                if (coll[i] != 0 || m_life[i] == 1) begin
                    m_act[i] = 0; m_life[i] = 0;
                end else begin
                    nx = m_x[i] + m_vx[i];
                    ny = m_y[i] + m_vy[i];
                    ox = (nx < 0) || (nx > 639 * 64);
                    oy = (ny < 0) || (ny > 479 * 64);
`ifdef BULLET_BOUNCE_EN
                    if (ox) m_vx[i] = -m_vx[i]; else m_x[i] = nx;
                    if (oy) m_vy[i] = -m_vy[i]; else m_y[i] = ny;
                    m_life[i] = m_life[i] - 1;
`else
                    if (ox || oy) begin
                        m_act[i] = 0; m_life[i] = 0;
                    end else begin
                        m_x[i] = nx; m_y[i] = ny;
                        m_life[i] = m_life[i] - 1;
                    end
`endif
                end
            end
        end
        if (acc != 0) begin
            m_act[fr]  = 1;
            m_x[fr]    = int'(tx) * 64;
            m_y[fr]    = int'(ty) * 64;
            m_vx[fr]   = int'(cs) * 2;
            m_vy[fr]   = int'(sn) * 2;
            m_life[fr] = 200;
        end
        if (acc != 0)      m_cd = 8;
        else if (m_cd > 0) m_cd = m_cd - 1;
        m_prev = shoot ? 1 : 0;
        m_hit  = hit_any;
    endtask

    // One frame: predict, queue the prediction, clock, then compare.
    task automatic frame();
        exp_t e;
        model_step();
        for (int i = 0; i < NB; i++) begin
            e.act[i]         = (m_act[i] != 0);
            e.x[10*i +: 10]  = 10'(m_x[i] / 64);
            e.y[10*i +: 10]  = 10'(m_y[i] / 64);
        end
        e.hit = (m_hit != 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        fcnt++;
        e = sb.pop_front();
        chk("active", 64'(bact), 64'(e.act));
        chk("posx",   64'(bx),   64'(e.x));
        chk("posy",   64'(by),   64'(e.y));
        chk("hit",    64'(hit),  64'(e.hit));
    endtask

    task automatic pulse(input int gap);
        shoot = 1'b1;
        frame();
        shoot = 1'b0;
        for (int i = 1; i < gap; i++) frame();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_active", 64'(bact), 64'd0);
        chk("rst_hit",    64'(hit),  64'd0);
        chk("rst_posx",   64'(bx),   64'd0);
        model_clear();
        shoot = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, guard;
        rst = 1'b1; shoot = 1'b0;
        tx = 10'd320; ty = 10'd240; sn = 8'sd0; cs = 8'sd64; ang = 6'd5;
        ex = 10'd1000; ey = 10'd1000; es = 10'd5;
        model_clear();
        #1;
        chk("init_active", 64'(bact), 64'd0);
        chk("init_hit",    64'(hit),  64'd0);
        chk("bullet_size", 64'(bs),   64'd2);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic shot moving right at 2 px/frame.
        shoot = 1'b1;
        frame();
        shoot = 1'b0;
        chk("spawn_x", 64'(bx[9:0]), 64'd320);
        chk("spawn_y", 64'(by[9:0]), 64'd240);
        frame(); chk("move1", 64'(bx[9:0]), 64'd322);
        frame(); chk("move2", 64'(bx[9:0]), 64'd324);
        frame(); chk("move3", 64'(bx[9:0]), 64'd326);
        for (int i = 0; i < 6; i++) frame();

        // Two more shots, then reset with three in flight.
        sn = -8'sd64; cs = 8'sd0;
        pulse(10);
        sn = 8'sd32; cs = -8'sd32; tx = 10'd200;
        pulse(10);
        chk("three_active", 64'($countones(bact)), 64'd3);
        apply_reset();

        // Held fire request spawns one bullet only.
        sn = 8'sd0; cs = 8'sd0; tx = 10'd100; ty = 10'd100;
        shoot = 1'b1;
        for (int i = 0; i < 50; i++) frame();
        shoot = 1'b0;
        chk("hold_one", 64'($countones(bact)), 64'd1);
        apply_reset();

        // Pulses every 4 frames against the cooldown.
        for (int p = 0; p < 6; p++) begin
            tx = 10'(50 + 60 * p);
            pulse(4);
        end
        for (int i = 0; i < 4; i++) frame();
        apply_reset();

        // Pool full: fifth shot dropped; slot0 expiry then refill.
        for (int p = 0; p < 5; p++) begin
            tx = 10'(100 + 50 * p);
            shoot = 1'b1;
            frame();
            shoot = 1'b0;
            if (p == 0) f0 = fcnt;
            for (int i = 1; i < 10; i++) frame();
        end
        chk("pool_full", 64'(bact), 64'hf);
        guard = 0;
        while (bact[0] && guard < 400) begin
            frame();
            guard++;
        end
        chk("lifetime", 64'(fcnt - f0), 64'd200);
        tx = 10'd600;
        pulse(2);
        chk("refill_act", 64'(bact), 64'hf);
        chk("refill_x",   64'(bx[9:0]), 64'd600);
        apply_reset();

        // Right-edge bound.
        tx = 10'd638; ty = 10'd240; cs = 8'sd64; sn = 8'sd0;
        shoot = 1'b1;
        frame();
        shoot = 1'b0;
        chk("edge_spawn", 64'(bx[9:0]), 64'd638);
        frame();
`ifdef BULLET_BOUNCE_EN
        chk("bounce_hold", 64'(bx[9:0]), 64'd638);
        frame(); chk("bounce_1", 64'(bx[9:0]), 64'd636);
        frame(); chk("bounce_2", 64'(bx[9:0]), 64'd634);
`else
        chk("edge_clear", 64'(bact[0]), 64'd0);
`endif
        for (int i = 0; i < 3; i++) frame();
        apply_reset();

        // Enemy contact.
        ex = 10'd400; ey = 10'd240; es = 10'd10;
        tx = 10'd380; ty = 10'd240; cs = 8'sd64; sn = 8'sd0;
        shoot = 1'b1;
        frame();
        shoot = 1'b0;
        for (int i = 0; i < 4; i++) frame();
        chk("pre_hit_x",   64'(bx[9:0]), 64'd388);
        chk("pre_hit",     64'(hit),     64'd0);
        frame();
        chk("hit_pulse",   64'(hit),     64'd1);
        chk("hit_cleared", 64'(bact),    64'd0);
        frame();
        chk("hit_end",     64'(hit),     64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
